// File: rtl/cpu_phase_pkg.sv
// cpu_phase_pkg: state encodings, default widths and latency constants shared by the phase sequencer and its bench
package cpu_phase_pkg;
    localparam int CNT_W_DEF   = 32;
    localparam int WAIT_W_DEF  = 4;
    localparam int MIN_LAT_ALU = 4;
    localparam int MIN_LAT_MEM = 5;
    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_FETCH   = 3'b001;
    localparam logic [2:0] ST_DECODE  = 3'b010;
    localparam logic [2:0] ST_EXECUTE = 3'b011;
    localparam logic [2:0] ST_MEMORY  = 3'b100;
    localparam logic [2:0] ST_WRITE   = 3'b101;
    localparam logic [2:0] ST_PAUSE   = 3'b110;
    localparam logic [2:0] ST_HALT    = 3'b111;
    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_EXECUTE = ST_EXECUTE,
        S_MEMORY  = ST_MEMORY,
        S_WRITE   = ST_WRITE,
        S_PAUSE   = ST_PAUSE,
        S_HALT    = ST_HALT
    } state_e;
endpackage

// File: rtl/cpu_phase_seq_wait_timer.sv
// phase_wait_timer: counts consecutive not-ready cycles of a memory handshake and flags the timeout
// Ports: clk, rst (sync, active-high), active (handshake phase in progress), ready (handshake done),
//        expire (MAX_WAIT-th consecutive not-ready cycle; a ready in that cycle suppresses it)
module phase_wait_timer
    import cpu_phase_pkg::*;
#(
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expire
);
    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic waiting;
    always_comb begin
        waiting = active && !ready;
        cnt_d   = waiting ? cnt_q + 1'b1 : '0;
        expire  = waiting && cnt_q == LAST;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cpu_phase_seq.sv
// cpu_phase_seq: multi-cycle fetch/decode/execute/memory/write sequencer with handshakes, step mode and timeout fault
// Ports: clk, rst (sync, active-high); run, halt_req, need_mem, need_wb, step_mode, step, imem_ready, dmem_ready in;
//        imem_req, dmem_req, if_en..pc_en phase enables, state, halted, fault, cycle_cnt, instret_cnt, stall_cnt out.
// Build option: define CPU_PHASE_STALL_CNT_EN to build the stall counter; otherwise stall_cnt is tied to 0.
module cpu_phase_seq
    import cpu_phase_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic             need_mem,
    input  logic             need_wb,
    input  logic             step_mode,
    input  logic             step,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    state_e state_q, state_d;
    logic fault_q, step_q, expire, wait_active, wait_ready, step_rise, live, active_cyc;
    logic [CNT_W-1:0] cycle_q, instret_q;
    phase_wait_timer #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .active (wait_active),
        .ready  (wait_ready),
        .expire (expire)
    );
    always_comb begin
        live        = !fault_q;
        wait_active = live && (state_q == S_FETCH || state_q == S_MEMORY);
        wait_ready  = state_q == S_FETCH ? imem_ready : dmem_ready;
        step_rise   = step && !step_q;
        active_cyc  = live && state_q != S_IDLE && state_q != S_HALT;
        state_d     = state_q;
        if (live) begin
            case (state_q)
                S_IDLE:    state_d = run ? S_FETCH : S_IDLE;
                S_FETCH:   state_d = imem_ready ? S_DECODE : S_FETCH;
                S_DECODE:  state_d = S_EXECUTE;
                S_EXECUTE: state_d = halt_req ? S_HALT : need_mem ? S_MEMORY : S_WRITE;
                S_MEMORY:  state_d = dmem_ready ? S_WRITE : S_MEMORY;
                S_WRITE:   state_d = step_mode ? S_PAUSE : S_FETCH;
                S_PAUSE:   state_d = (!step_mode || step_rise) ? S_FETCH : S_PAUSE;
                default:   state_d = S_HALT;
            endcase
        end
        if_en    = live && state_q == S_FETCH;
        imem_req = if_en;
        id_en    = live && state_q == S_DECODE;
        ex_en    = live && state_q == S_EXECUTE;
        dmem_req = live && state_q == S_MEMORY;
        pc_en    = live && state_q == S_WRITE;
        mem_en   = dmem_req || pc_en;
        wb_en    = pc_en && need_wb;
        halted   = live && state_q == S_HALT;
        fault    = fault_q;
        state    = fault_q ? ST_HALT : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fault_q   <= 1'b0;
            step_q    <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_q || expire;
            step_q    <= step;
            cycle_q   <= cycle_q + CNT_W'(active_cyc);
            instret_q <= instret_q + CNT_W'(pc_en);
        end
    end
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`ifdef CPU_PHASE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_q + CNT_W'(wait_active && !wait_ready);
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule
